// File: rtl/cla_pkg.sv
// Shared constants and parameter helpers for the pipelined carry-lookahead adder.
package cla_pkg;

    localparam int GROUP_W = 4;

    function automatic int stage_count(int width, int groups_per_stage);
        return width / (GROUP_W * groups_per_stage);
    endfunction

    function automatic bit params_legal(int width, int groups_per_stage);
        return (width % GROUP_W == 0) && (width >= 4) && (width <= 64) &&
               (groups_per_stage >= 1) &&
               ((width / GROUP_W) % groups_per_stage == 0);
    endfunction

endpackage

// File: rtl/pipe_cla_adder_if.sv
// Operand/result handshake bundle between a producer/consumer and pipe_cla_adder.
interface pipe_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_group.sv
// One 4-bit carry-lookahead group: every internal carry is a flat G/P sum of products.
module cla_group
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               c_in,
    output logic [GROUP_W-1:0] s,
    output logic               c_out,
    output logic               p,
    output logic               g
);
    logic [GROUP_W-1:0] gen;
    logic [GROUP_W-1:0] prop;
    logic [GROUP_W-1:0] c;

    assign gen  = a & b;
    assign prop = a ^ b;

    assign c[0] = c_in;
    assign c[1] = gen[0] | (prop[0] & c_in);
    assign c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & c_in);
    assign c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0]) |
                  (prop[2] & prop[1] & prop[0] & c_in);

    assign p = &prop;
    assign g = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1]) |
               (prop[3] & prop[2] & prop[1] & gen[0]);

    assign c_out = g | (p & c_in);
    assign s     = prop ^ c;
endmodule

// File: rtl/pipe_cla_adder.sv
// Pipelined add/subtract: each stage resolves GROUPS_PER_STAGE CLA groups, operands skew
// forward and finished sum slices ride along so the whole result leaves in one cycle.
module pipe_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH            = 16,
    parameter int GROUPS_PER_STAGE = 1
) (
    input logic           clk,
    input logic           rst_n,
    pipe_cla_adder_if.slave bus
);
    localparam int STAGES = stage_count(WIDTH, GROUPS_PER_STAGE);
    localparam int NGRP   = WIDTH / GROUP_W;
    localparam int LAST   = STAGES - 1;

    if (!params_legal(WIDTH, GROUPS_PER_STAGE)) begin : g_bad_params
        $error("pipe_cla_adder: illegal WIDTH / GROUPS_PER_STAGE combination");
    end

    logic [WIDTH-1:0]   a_q [STAGES];
    logic [WIDTH-1:0]   a_d [STAGES];
    logic [WIDTH-1:0]   b_q [STAGES];
    logic [WIDTH-1:0]   b_d [STAGES];
    logic [WIDTH-1:0]   s_q [STAGES];
    logic [WIDTH-1:0]   s_d [STAGES];
    logic [STAGES-1:0]  c_q, c_d;
    logic [STAGES-1:0]  v_q, v_d;

    logic [WIDTH-1:0]   st_a [STAGES];
    logic [WIDTH-1:0]   st_b [STAGES];
    logic [WIDTH-1:0]   st_s [STAGES];
    logic [STAGES-1:0]  st_c, st_v;

    logic [GROUP_W-1:0] grp_s [NGRP];
    logic [NGRP-1:0]    grp_co, grp_p, grp_g;
    logic               advance;
    logic               unused_pg;

    // One global enable: a stalled output freezes every stage, bubbles included.
    assign advance = ~v_q[LAST] | bus.out_ready;

    // Stage 0 sees the live operands with b pre-inverted for subtraction; later stages
    // see the skew registers of the stage before them.
    always_comb begin
        st_a[0] = bus.a;
        st_b[0] = bus.sub ? ~bus.b : bus.b;
        st_s[0] = '0;
        st_c[0] = bus.sub | bus.cin;
        st_v[0] = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            st_a[k] = a_q[k-1];
            st_b[k] = b_q[k-1];
            st_s[k] = s_q[k-1];
            st_c[k] = c_q[k-1];
            st_v[k] = v_q[k-1];
        end
    end

    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
        localparam int K = gi / GROUPS_PER_STAGE;
        logic ci;
        if (gi % GROUPS_PER_STAGE == 0) begin : g_first
            assign ci = st_c[K];
        end else begin : g_ripple
            assign ci = grp_co[gi-1];
        end
        cla_group u_group (
            .a     (st_a[K][gi*GROUP_W +: GROUP_W]),
            .b     (st_b[K][gi*GROUP_W +: GROUP_W]),
            .c_in  (ci),
            .s     (grp_s[gi]),
            .c_out (grp_co[gi]),
            .p     (grp_p[gi]),
            .g     (grp_g[gi])
        );
    end

    assign unused_pg = ^{grp_p, grp_g};

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and a latch cannot be inferred.
            a_d[k] = a_q[k];
            b_d[k] = b_q[k];
            s_d[k] = s_q[k];
            c_d[k] = c_q[k];
            v_d[k] = v_q[k];
            if (advance) begin
                a_d[k] = st_a[k];
                b_d[k] = st_b[k];
                s_d[k] = st_s[k];
                for (int j = 0; j < GROUPS_PER_STAGE; j++) begin
                    s_d[k][(k*GROUPS_PER_STAGE + j)*GROUP_W +: GROUP_W] =
                        grp_s[k*GROUPS_PER_STAGE + j];
                end
                c_d[k] = grp_co[(k+1)*GROUPS_PER_STAGE - 1];
                v_d[k] = st_v[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these arrays are pipeline flops, not RAM, so each element is cleared on reset like any other register.
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            c_q <= '0;
            v_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every stage samples its predecessor's pre-edge value.
            a_q <= a_d;
            b_q <= b_d;
            s_q <= s_d;
            c_q <= c_d;
            v_q <= v_d;
        end
    end

    // Carry into the MSB is recovered from the MSB sum bit and its (effective) operands.
    assign bus.in_ready  = advance;
    assign bus.out_valid = v_q[LAST];
    assign bus.sum       = s_q[LAST];
    assign bus.cout      = c_q[LAST];
    assign bus.ovf       = s_q[LAST][WIDTH-1] ^ a_q[LAST][WIDTH-1] ^
                           b_q[LAST][WIDTH-1] ^ c_q[LAST];
endmodule

// File: tb/tb_pipe_cla_adder.sv
// Self-checking bench for pipe_cla_adder in three configurations: 4/1, 16/1 and 32/2.
module tb_pipe_cla_adder;

    typedef struct packed {
        logic        ovf;
        logic        cout;
        logic [63:0] sum;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec16_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_cla_adder_if #(.WIDTH(4))  if4 ();
    pipe_cla_adder_if #(.WIDTH(16)) if16 ();
    pipe_cla_adder_if #(.WIDTH(32)) if32 ();

    pipe_cla_adder #(.WIDTH(4),  .GROUPS_PER_STAGE(1)) u_dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
    pipe_cla_adder #(.WIDTH(16), .GROUPS_PER_STAGE(1)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    pipe_cla_adder #(.WIDTH(32), .GROUPS_PER_STAGE(2)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic res_t model(int w, longint unsigned a, longint unsigned b, bit cin, bit sub);
        longint unsigned modv, tot;
        longint          half, sa, sb, sr;
        res_t            r;
        modv   = 64'd1 << w;
        half   = longint'(modv >> 1);
        tot    = sub ? (a + modv - b) : (a + b + 64'(cin));
        r.sum  = tot & (modv - 64'd1);
        r.cout = tot[w];
        sa     = (a >= modv / 2) ? longint'(a) - longint'(modv) : longint'(a);
        sb     = (b >= modv / 2) ? longint'(b) - longint'(modv) : longint'(b);
        sr     = sub ? (sa - sb) : (sa + sb + longint'(cin));
        r.ovf  = (sr < -half) || (sr >= half);
        return r;
    endfunction

    // Scoreboard for the 16-bit streaming phases, sampled mid-cycle.
    res_t        q16[$];
    bit          mon16_en   = 1'b0;
    bit          prev_stall = 1'b0;
    logic [65:0] prev_out;
    int          got16 = 0;

    always @(negedge clk) begin
        if (mon16_en) begin
            check("w16_in_ready_rule", 66'(if16.in_ready), 66'(!if16.out_valid || if16.out_ready));
            if (prev_stall && if16.out_valid)
                check("w16_stall_hold", {if16.ovf, if16.cout, 48'd0, if16.sum}, prev_out);
            prev_stall = if16.out_valid && !if16.out_ready;
            prev_out   = {if16.ovf, if16.cout, 48'd0, if16.sum};
            if (if16.out_valid && if16.out_ready) begin
                if (q16.size() == 0) begin
                    check("w16_spurious_out", 66'(if16.out_valid), 66'd0);
                end else begin
                    check("w16_stream_result", {if16.ovf, if16.cout, 48'd0, if16.sum}, q16.pop_front());
                    got16++;
                end
            end
            if (if16.in_valid && if16.in_ready)
                q16.push_back(model(16, 64'(if16.a), 64'(if16.b), if16.cin, if16.sub));
        end
    end

    task automatic drive16_random();
        if16.a        = 16'($urandom);
        if16.b        = 16'($urandom);
        if16.cin      = 1'($urandom);
        if16.sub      = 1'($urandom);
        if16.in_valid = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    vec16_t tbl[9];
    res_t   exp4, r32;
    int     lat, sent, cyc, stale;
    bit     acc;

    initial begin
        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        tbl[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        tbl[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[8] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};

        if4.in_valid = 0;  if4.a = '0;  if4.b = '0;  if4.cin = 0;  if4.sub = 0;  if4.out_ready = 1;
        if16.in_valid = 0; if16.a = '0; if16.b = '0; if16.cin = 0; if16.sub = 0; if16.out_ready = 1;
        if32.in_valid = 0; if32.a = '0; if32.b = '0; if32.cin = 0; if32.sub = 0; if32.out_ready = 1;
        rst_n = 1'b0;

        // Reset state.
        #3;
        check("rst_in_ready_4",   66'(if4.in_ready), 66'd1);
        check("rst_out_valid_4",  66'(if4.out_valid), 66'd0);
        check("rst_in_ready_16",  66'(if16.in_ready), 66'd1);
        check("rst_outputs_16",   {if16.out_valid, if16.ovf, 47'd0, if16.cout, if16.sum}, 66'd0);
        check("rst_outputs_32",   {if32.out_valid, if32.ovf, 31'd0, if32.cout, if32.sum}, 66'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready_16", 66'(if16.in_ready), 66'd1);

        // WIDTH=4: exhaustive a, b, cin, sub streamed back-to-back with latency 1.
        for (int i = 0; i <= 1024; i++) begin
            @(posedge clk); #1;
            if (i > 0) begin
                check("w4_valid", 66'(if4.out_valid), 66'd1);
                check("w4_result", {if4.ovf, if4.cout, 60'd0, if4.sum}, exp4);
            end
            if (i < 1024) begin
                if4.a = i[3:0]; if4.b = i[7:4]; if4.cin = i[8]; if4.sub = i[9];
                if4.in_valid = 1'b1;
                exp4 = model(4, 64'(i[3:0]), 64'(i[7:4]), i[8], i[9]);
            end else begin
                if4.in_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        check("w4_drained", 66'(if4.out_valid), 66'd0);

        // WIDTH=16 directed vectors, one at a time, with latency measurement.
        foreach (tbl[i]) begin
            @(posedge clk); #1;
            if16.a = tbl[i].a; if16.b = tbl[i].b; if16.cin = tbl[i].cin; if16.sub = tbl[i].sub;
            if16.in_valid = 1'b1;
            check("w16_vec_in_ready", 66'(if16.in_ready), 66'd1);
            @(posedge clk); #1;
            if16.in_valid = 1'b0;
            lat = 1;
            while (!if16.out_valid && lat < 16) begin
                @(posedge clk); #1;
                lat++;
            end
            check("w16_vec_latency", 66'(lat), 66'd4);
            check("w16_vec_sum",  66'(if16.sum),  66'(tbl[i].sum));
            check("w16_vec_cout", 66'(if16.cout), 66'(tbl[i].cout));
            check("w16_vec_ovf",  66'(if16.ovf),  66'(tbl[i].ovf));
        end
        repeat (6) @(posedge clk);
        #1;

        // WIDTH=16: 20 back-to-back random operands with a 3-cycle consumer stall.
        prev_stall = 1'b0;
        mon16_en   = 1'b1;
        sent = 0; cyc = 0;
        while (sent < 20 && cyc < 200) begin
            if16.out_ready = !(cyc >= 10 && cyc < 13);
            if (!if16.in_valid) drive16_random();
            @(negedge clk);
            acc = if16.in_ready;
            if (cyc >= 10 && cyc < 13) check("w16_stall_in_ready", 66'(if16.in_ready), 66'd0);
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                sent++;
                if16.in_valid = 1'b0;
            end
        end
        if16.out_ready = 1'b1;
        for (int k = 0; k < 50 && got16 < 20; k++) @(posedge clk);
        #1;
        check("w16_burst_count", 66'(got16), 66'd20);

        // WIDTH=16: random valid gaps and random back-pressure.
        cyc = 0;
        while (sent < 60 && cyc < 600) begin
            if16.out_ready = ($urandom_range(0, 3) != 0);
            if (!if16.in_valid && $urandom_range(0, 9) < 7) drive16_random();
            @(negedge clk);
            acc = if16.in_valid && if16.in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                sent++;
                if16.in_valid = 1'b0;
            end
        end
        if16.in_valid  = 1'b0;
        if16.out_ready = 1'b1;
        for (int k = 0; k < 50 && got16 < 60; k++) @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        check("w16_random_count", 66'(got16), 66'd60);
        check("w16_queue_empty", 66'(q16.size()), 66'd0);
        mon16_en = 1'b0;

        // WIDTH=32, 2 groups/stage: reset while operations are in flight.
        if32.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if32.a = $urandom; if32.b = $urandom; if32.cin = 1'($urandom); if32.sub = 1'($urandom);
            if32.in_valid = 1'b1;
        end
        @(posedge clk); #1;
        if32.in_valid = 1'b0;
        @(posedge clk); #1;
        check("w32_first_emerged", 66'(if32.out_valid), 66'd1);
        #2 rst_n = 1'b0;
        #1;
        check("w32_rst_out_valid", 66'(if32.out_valid), 66'd0);
        check("w32_rst_outputs", {if32.ovf, if32.cout, 32'd0, if32.sum}, 66'd0);
        check("w32_rst_in_ready", 66'(if32.in_ready), 66'd1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        if32.out_ready = 1'b1;
        stale = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (if32.out_valid) stale++;
        end
        check("w32_no_stale", 66'(stale), 66'd0);

        @(posedge clk); #1;
        if32.a = 32'hFFFF_FFFF; if32.b = 32'h0000_0001; if32.cin = 1'b0; if32.sub = 1'b0;
        if32.in_valid = 1'b1;
        @(posedge clk); #1;
        if32.in_valid = 1'b0;
        lat = 1;
        while (!if32.out_valid && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w32_latency", 66'(lat), 66'd4);
        check("w32_wrap_result", {if32.ovf, if32.cout, 32'd0, if32.sum}, {1'b0, 1'b1, 64'd0});

        @(posedge clk); #1;
        if32.a = $urandom; if32.b = $urandom; if32.cin = 1'($urandom); if32.sub = 1'($urandom);
        if32.in_valid = 1'b1;
        r32 = model(32, 64'(if32.a), 64'(if32.b), if32.cin, if32.sub);
        @(posedge clk); #1;
        if32.in_valid = 1'b0;
        lat = 1;
        while (!if32.out_valid && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w32_rand_latency", 66'(lat), 66'd4);
        check("w32_rand_result", {if32.ovf, if32.cout, 32'd0, if32.sum}, r32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
